// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, RISC-V
// load/store size codes, byte-enable generation and load-data extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    // Half and word ignore the low address bits below their size (aligned down).
    function automatic logic [3:0] be_from_size(input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << addr_lo;
            F3_H, F3_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  addr_lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'b0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'b0, h};
            F3_W:    r = word;
            default: r = 32'b0;
        endcase
        return r;
    endfunction

    // Replicate store data across every lane so the byte enables pick the right one.
    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        logic [31:0] r;
        case (funct3)
            F3_B, F3_BU: r = {4{wdata[7:0]}};
            F3_H, F3_HU: r = {2{wdata[15:0]}};
            default:     r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port; contents are never reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: valid/ready request,
// WAIT_CYCLES wait states, then a held response. Define DMEM_ERR_EN for error checks.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    logic [2:0]         f3_eff_c;
    logic               err_c;
    logic               access_c;
    logic               ram_we_c;
    logic [IDX_W-1:0]   ram_addr_c;
    logic [31:0]        ram_rdata;

`ifdef DMEM_ERR_EN
    always_comb begin
        f3_eff_c = funct3_q;
        err_c    = !f3_legal(funct3_q)
                || (((funct3_q == F3_H) || (funct3_q == F3_HU)) && addr_q[0])
                || ((funct3_q == F3_W) && (addr_q[1:0] != 2'b00))
                || ((addr_q >> (IDX_W + 2)) != '0);
    end
`else
    // Address bits above the array wrap away; illegal sizes behave as words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W+2];

    always_comb begin
        f3_eff_c = f3_legal(funct3_q) ? funct3_q : F3_W;
        err_c    = 1'b0;
    end
`endif

    // The RAM reads every cycle, so the word for the latched request is ready
    // by the first edge spent in RESP, whatever WAIT_CYCLES is.
    assign access_c   = (state_q == RESP) && !resp_valid_q;
    assign ram_we_c   = access_c && we_q && !err_c;
    assign ram_addr_c = (state_q == IDLE) ? req_addr[IDX_W+1:2] : addr_q[IDX_W+1:2];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we_c),
        .be    (be_from_size(f3_eff_c, addr_q[1:0])),
        .addr  (ram_addr_c),
        .wdata (store_lanes(f3_eff_c, wdata_q)),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (access_c) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_c;
                    resp_rdata_d = (we_q || err_c) ? 32'b0
                                 : load_extend(f3_eff_c, addr_q[1:0], ram_rdata);
                end else if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'b0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'b0;
            funct3_q     <= 3'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a zero-wait
// instance; error cases follow whether DMEM_ERR_EN is defined.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [2:0]  req_funct3;

    logic        z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
    logic [2:0]  z_req_funct3;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut_zw (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction on either instance; samples land 1 time unit after edges.
    task automatic xact_chk(input string tag, input bit zw, input bit we,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] f3, input logic [31:0] exp_rd,
                            input logic exp_err);
        int          lat;
        logic [31:0] rd;
        logic        e;
        if (zw) begin
            z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr;
            z_req_wdata = wd;   z_req_funct3 = f3;
        end else begin
            req_valid = 1'b1; req_we = we; req_addr = addr;
            req_wdata = wd;   req_funct3 = f3;
        end
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        req_valid   = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(zw ? z_resp_valid : resp_valid) && lat < 20);
        rd = zw ? z_resp_rdata : resp_rdata;
        e  = zw ? z_resp_err : resp_err;
        check({tag, ".lat"}, 32'(lat), zw ? 32'd1 : 32'd3);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, 32'(e), 32'(exp_err));
        if (zw) z_resp_ready = 1'b1; else resp_ready = 1'b1;
        @(posedge clk); #1;
        z_resp_ready = 1'b0;
        resp_ready   = 1'b0;
        check({tag, ".ready_after"}, 32'(zw ? z_req_ready : req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = F3_W;
        resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_funct3 = F3_W;
        z_resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        check("rst.resp_err", 32'(resp_err), 32'd0);

        xact_chk("sw10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 1'b0);
        xact_chk("lw10", 1'b0, 1'b0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 1'b0);

        xact_chk("sb11", 1'b0, 1'b1, 32'h11, 32'h00000080, F3_B, 32'h0, 1'b0);
        xact_chk("lw10b", 1'b0, 1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD80EF, 1'b0);
        xact_chk("lb11", 1'b0, 1'b0, 32'h11, 32'h0, F3_B, 32'hFFFFFF80, 1'b0);
        xact_chk("lbu11", 1'b0, 1'b0, 32'h11, 32'h0, F3_BU, 32'h00000080, 1'b0);
        xact_chk("lhu12", 1'b0, 1'b0, 32'h12, 32'h0, F3_HU, 32'h0000DEAD, 1'b0);
        xact_chk("lh12", 1'b0, 1'b0, 32'h12, 32'h0, F3_H, 32'hFFFFDEAD, 1'b0);
        xact_chk("sh0", 1'b0, 1'b1, 32'h0, 32'hFFFFF00D, F3_H, 32'h0, 1'b0);
        xact_chk("sh2", 1'b0, 1'b1, 32'h2, 32'h00000BAD, F3_H, 32'h0, 1'b0);
        xact_chk("lw0", 1'b0, 1'b0, 32'h0, 32'h0, F3_W, 32'h0BADF00D, 1'b0);

        // Response backpressure with a competing request that must be ignored.
        begin
            int lat;
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_W;
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!resp_valid && lat < 20);
            check("bp.lat", 32'(lat), 32'd3);
            for (int i = 0; i < 5; i++) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
                req_wdata = 32'h11111111; req_funct3 = F3_W;
                @(posedge clk); #1;
                check("bp.resp_valid", 32'(resp_valid), 32'd1);
                check("bp.resp_rdata", resp_rdata, 32'hDEAD80EF);
                check("bp.req_ready", 32'(req_ready), 32'd0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            check("bp.done_valid", 32'(resp_valid), 32'd0);
            check("bp.done_rdata", resp_rdata, 32'h0);
            check("bp.done_ready", 32'(req_ready), 32'd1);
        end
        xact_chk("bp.lw10", 1'b0, 1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD80EF, 1'b0);

`ifdef DMEM_ERR_EN
        xact_chk("err.lw02", 1'b0, 1'b0, 32'h02, 32'h0, F3_W, 32'h0, 1'b1);
        xact_chk("err.lh11", 1'b0, 1'b0, 32'h11, 32'h0, F3_H, 32'h0, 1'b1);
        xact_chk("err.f3_011", 1'b0, 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
        xact_chk("err.sw400", 1'b0, 1'b1, 32'h400, 32'h12345678, F3_W, 32'h0, 1'b1);
        xact_chk("err.sb12", 1'b0, 1'b1, 32'h12, 32'h00000055, 3'b111, 32'h0, 1'b1);
        xact_chk("err.lw0", 1'b0, 1'b0, 32'h0, 32'h0, F3_W, 32'h0BADF00D, 1'b0);
        xact_chk("err.lw10", 1'b0, 1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD80EF, 1'b0);
`else
        xact_chk("wrap.lw402", 1'b0, 1'b0, 32'h402, 32'h0, F3_W, 32'h0BADF00D, 1'b0);
        xact_chk("align.lw12", 1'b0, 1'b0, 32'h12, 32'h0, F3_W, 32'hDEAD80EF, 1'b0);
        xact_chk("align.lhu13", 1'b0, 1'b0, 32'h13, 32'h0, F3_HU, 32'h0000DEAD, 1'b0);
        xact_chk("f3_011.lw", 1'b0, 1'b0, 32'h10, 32'h0, 3'b011, 32'hDEAD80EF, 1'b0);
`endif

        // Reset during WAIT must drop the pending store.
        xact_chk("abort.sw20", 1'b0, 1'b1, 32'h20, 32'h55AA55AA, F3_W, 32'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; req_funct3 = F3_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort.in_wait", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort.req_ready", 32'(req_ready), 32'd1);
        check("abort.resp_valid", 32'(resp_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort.idle_valid", 32'(resp_valid), 32'd0);
        xact_chk("abort.lw20", 1'b0, 1'b0, 32'h20, 32'h0, F3_W, 32'h55AA55AA, 1'b0);

        xact_chk("zw.sw8", 1'b1, 1'b1, 32'h8, 32'h13579BDF, F3_W, 32'h0, 1'b0);
        xact_chk("zw.lw8", 1'b1, 1'b0, 32'h8, 32'h0, F3_W, 32'h13579BDF, 1'b0);
        xact_chk("zw.lbu9", 1'b1, 1'b0, 32'h9, 32'h0, F3_BU, 32'h0000009B, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
